can_receiver: RTL and testbench
===============================

CAN_RECEIVER -- requirements
Module: can_receiver

Interface
REQ-001 SHALL have the port `clk`, an input of width 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have the port `rst_n`, an input of width 1: asynchronous, active-low reset.
REQ-003 SHALL have the port `sample_point`, an input of width 1: one-cycle strobe; `rx_bit` is consumed only in cycles where it is 1.
REQ-004 SHALL have the port `rx_bit`, an input of width 1: bus level (0 = dominant, 1 = recessive).
REQ-005 SHALL have the ports `rx_data_0` through `rx_data_9`, outputs of width 8 each, carrying the received frame:
- `rx_data_0` = ID[10:3].
- `rx_data_1` = {ID[2:0], RTR, DLC[3:0]}.
- `rx_data_2` through `rx_data_9` = data bytes 1 through 8.
REQ-006 SHALL have the port `rx_done`, an output of width 1: one-cycle pulse when a frame completes without error.
REQ-007 SHALL have the port `ack_bit`, an output of width 1: value this node drives during the ACK slot; 1 at all other times.
REQ-008 SHALL have the port `crc_error`, an output of width 1: one-cycle pulse.
REQ-009 SHALL have the port `stuff_error`, an output of width 1: one-cycle pulse.
REQ-010 SHALL have the port `form_error`, an output of width 1: one-cycle pulse.
REQ-011 SHALL have the port `rx_busy`, an output of width 1: 1 from SOF until return to IDLE.

Function
REQ-012 SHALL advance all FSM, counter, CRC and stuff logic only on cycles with `sample_point`=1; other cycles hold state.
REQ-013 SHALL implement states IDLE, ID, RTR, IDE, R0, DLC, DATA, CRC, CRC_DELIM, ACK_SLOT, ACK_DELIM, EOF and WAIT_IDLE.
REQ-014 SHALL leave IDLE for ID when a dominant bit is sampled; that bit is the SOF.
REQ-015 SHALL take, in order:
- ID: 11 bits, MSB first.
- RTR: 1 bit.
- IDE: 1 bit.
- R0: 1 bit.
- DLC: 4 bits, MSB first.
- DATA: 8*N bits, MSB first per byte.
- CRC: 15 bits.
- Then CRC_DELIM, ACK_SLOT, ACK_DELIM, and 7 bits of EOF.
REQ-016 SHALL set N = 0 if RTR=1, else N = min(DLC, 8); when N=0, DLC is followed directly by CRC.
REQ-017 SHALL apply destuffing from SOF through the last CRC bit:
- After 5 consecutive equal bits (after destuffing), the next sampled bit is a stuff bit and is discarded.
- If that stuff bit equals the preceding bit, this is a stuff error.
- The stuffed bit counts as the first bit of the next run.
REQ-018 SHALL compute CRC-15 (polynomial 0x4599, initial value 0) over destuffed bits from SOF through the last data bit, then compare it with the received CRC field.
REQ-019 SHALL drive `ack_bit`=0 for exactly the ACK_SLOT bit time if the CRC matched; otherwise `ack_bit` stays 1 and a `crc_error` pulse is raised on entry to ACK_SLOT.
REQ-020 SHALL treat each of the following as a form error: CRC_DELIM=0, ACK_DELIM=0, any EOF bit=0, IDE=1 (extended frames unsupported).
REQ-021 SHALL treat a frame as complete when the 7th EOF bit is recessive and no error has occurred; in the following clock cycle, `rx_done`=1 for one cycle and the FSM returns to IDLE.
REQ-022 SHALL update `rx_data_*` only at `rx_done`; they hold their previous values otherwise, including after errors.
REQ-023 SHALL copy unused data bytes (index > N) as 0x00.
REQ-024 SHALL, on any error:
- Pulse the corresponding error flag for one cycle.
- Suppress `rx_done`.
- Enter WAIT_IDLE.
REQ-025 SHALL leave WAIT_IDLE for IDLE after 11 consecutive recessive bits are sampled; any dominant bit restarts the count.
REQ-026 SHALL give `stuff_error` priority if stuff and CRC errors coincide in the same sample.

Reset
REQ-027 SHALL, while `rst_n`=0, immediately force:
- FSM state to IDLE.
- All counters and the CRC register to 0.
- `rx_data_*` to 0x00.
- `rx_done`, `crc_error`, `stuff_error`, `form_error` and `rx_busy` to 0.
- `ack_bit` to 1.
REQ-028 SHALL discard any partially received frame when reset is asserted mid-frame; after release, the block waits in IDLE for the next SOF.

Verification
REQ-029 SHALL cover a valid frame: ID=0x554, RTR=0, DLC=8, data 11..88, correct CRC, stuffed → `ack_bit`=0 in the ACK slot; `rx_done` pulses; `rx_data_0`=0xAA, `rx_data_1`=0x88, `rx_data_2`..`rx_data_9`=0x11..0x88.
REQ-030 SHALL cover a stuff violation: 6 equal bits inside the ID field → `stuff_error` pulse, no `rx_done`, `rx_data_*` unchanged, IDLE after 11 recessive bits.
REQ-031 SHALL cover a CRC violation: one data bit flipped in an otherwise valid frame → `ack_bit` stays 1, `crc_error` pulse, no `rx_done`.
REQ-032 SHALL cover a remote frame: RTR=1, DLC=4 → no data bits consumed; `rx_done` pulses; `rx_data_1` RTR bit =1; `rx_data_2`..`rx_data_9`=0x00.
REQ-033 SHALL cover form errors: CRC_DELIM driven dominant → `form_error` pulse; separately, IDE=1 → `form_error` pulse.
REQ-034 SHALL cover reset mid-frame: `rst_n`=0 during DATA → outputs at reset values immediately; a following valid frame is received correctly.

Source files
------------

// File: rtl/can_receiver.sv
// -----------------------------------------------------------------------------
// can_receiver
//
// Bit-level CAN 2.0A (standard, 11-bit identifier) frame receiver. The block is
// fed already-synchronised bus samples. It removes stuff bits, checks CRC-15
// and frame form, drives the ACK slot, and presents the received frame as ten
// bytes.
//
// Ports
//   clk          : single clock; all state changes on its rising edge
//   rst_n        : asynchronous active-low reset
//   sample_point : one-cycle strobe; rx_bit is consumed only when it is 1
//   rx_bit       : bus level (0 = dominant, 1 = recessive)
//   rx_data_0    : ID[10:3]
//   rx_data_1    : {ID[2:0], RTR, DLC[3:0]}
//   rx_data_2..9 : data bytes 1..8 (bytes beyond the data length read 0x00)
//   rx_done      : one-cycle pulse after a frame completes without error
//   ack_bit      : level this node drives; 0 only during ACK slot of a good frame
//   crc_error    : one-cycle pulse, CRC mismatch detected
//   stuff_error  : one-cycle pulse, stuff rule violated
//   form_error   : one-cycle pulse, fixed-form bit wrong or IDE=1
//   rx_busy      : high from SOF until the receiver is back in IDLE
// -----------------------------------------------------------------------------
module can_receiver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_point,
    input  logic       rx_bit,
    output logic [7:0] rx_data_0,
    output logic [7:0] rx_data_1,
    output logic [7:0] rx_data_2,
    output logic [7:0] rx_data_3,
    output logic [7:0] rx_data_4,
    output logic [7:0] rx_data_5,
    output logic [7:0] rx_data_6,
    output logic [7:0] rx_data_7,
    output logic [7:0] rx_data_8,
    output logic [7:0] rx_data_9,
    output logic       rx_done,
    output logic       ack_bit,
    output logic       crc_error,
    output logic       stuff_error,
    output logic       form_error,
    output logic       rx_busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_RTR,
        ST_IDE,
        ST_R0,
        ST_DLC,
        ST_DATA,
        ST_CRC,
        ST_CRC_DELIM,
        ST_ACK_SLOT,
        ST_ACK_DELIM,
        ST_EOF,
        ST_WAIT_IDLE
    } state_t;

    localparam logic [14:0] CRC_POLY = 15'h4599;

    state_t      state_reg,    state_next;
    logic [6:0]  bit_cnt_reg,  bit_cnt_next;
    logic [2:0]  run_cnt_reg,  run_cnt_next;
    logic        last_bit_reg, last_bit_next;
    logic [14:0] crc_reg,      crc_next;
    logic [14:0] crc_rx_reg,   crc_rx_next;
    logic [10:0] id_reg,       id_next;
    logic        rtr_reg,      rtr_next;
    logic [3:0]  dlc_reg,      dlc_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic [7:0]  data_reg    [0:7];
    logic [7:0]  data_next   [0:7];
    logic [7:0]  rx_data_reg [0:9];
    logic [7:0]  rx_data_next[0:9];
    logic        rx_done_reg,     rx_done_next;
    logic        crc_error_reg,   crc_error_next;
    logic        stuff_error_reg, stuff_error_next;
    logic        form_error_reg,  form_error_next;

    // Helper signals of the next-state process
    logic        destuff_active;
    logic        stuff_slot;
    logic        enter_wait;
    logic [3:0]  n_bytes;
    logic [3:0]  dlc_shift;

    // Number of data bytes carried by a frame: remote frames carry none,
    // DLC values 9..15 mean 8 bytes.
    function automatic logic [3:0] frame_bytes(input logic rtr, input logic [3:0] dlc);
        if (rtr)
            return 4'd0;
        else if (dlc > 4'd8)
            return 4'd8;
        else
            return dlc;
    endfunction

    function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic din);
        logic        fb;
        logic [14:0] shifted;
        fb      = din ^ crc[14];
        shifted = {crc[13:0], 1'b0};
        return fb ? (shifted ^ CRC_POLY) : shifted;
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            bit_cnt_reg     <= '0;
            run_cnt_reg     <= '0;
            last_bit_reg    <= 1'b1;
            crc_reg         <= '0;
            crc_rx_reg      <= '0;
            id_reg          <= '0;
            rtr_reg         <= 1'b0;
            dlc_reg         <= '0;
            wait_cnt_reg    <= '0;
            rx_done_reg     <= 1'b0;
            crc_error_reg   <= 1'b0;
            stuff_error_reg <= 1'b0;
            form_error_reg  <= 1'b0;
            for (int i = 0; i < 8; i++) data_reg[i] <= '0;
            for (int i = 0; i < 10; i++) rx_data_reg[i] <= '0;
        end else begin
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            run_cnt_reg     <= run_cnt_next;
            last_bit_reg    <= last_bit_next;
            crc_reg         <= crc_next;
            crc_rx_reg      <= crc_rx_next;
            id_reg          <= id_next;
            rtr_reg         <= rtr_next;
            dlc_reg         <= dlc_next;
            wait_cnt_reg    <= wait_cnt_next;
            rx_done_reg     <= rx_done_next;
            crc_error_reg   <= crc_error_next;
            stuff_error_reg <= stuff_error_next;
            form_error_reg  <= form_error_next;
            for (int i = 0; i < 8; i++) data_reg[i] <= data_next[i];
            for (int i = 0; i < 10; i++) rx_data_reg[i] <= rx_data_next[i];
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        bit_cnt_next     = bit_cnt_reg;
        run_cnt_next     = run_cnt_reg;
        last_bit_next    = last_bit_reg;
        crc_next         = crc_reg;
        crc_rx_next      = crc_rx_reg;
        id_next          = id_reg;
        rtr_next         = rtr_reg;
        dlc_next         = dlc_reg;
        wait_cnt_next    = wait_cnt_reg;
        rx_done_next     = 1'b0;
        crc_error_next   = 1'b0;
        stuff_error_next = 1'b0;
        form_error_next  = 1'b0;
        for (int i = 0; i < 8; i++) data_next[i] = data_reg[i];
        for (int i = 0; i < 10; i++) rx_data_next[i] = rx_data_reg[i];
        enter_wait       = 1'b0;
        dlc_shift        = {dlc_reg[2:0], rx_bit};
        n_bytes          = frame_bytes(rtr_reg, dlc_reg);

        // Destuffing covers ID through the last CRC bit. The bit after the
        // final CRC bit is the CRC delimiter, never a stuff bit.
        destuff_active = (state_reg inside {ST_ID, ST_RTR, ST_IDE, ST_R0,
                                            ST_DLC, ST_DATA, ST_CRC});
        stuff_slot     = destuff_active && (run_cnt_reg == 3'd5);

        if (sample_point) begin
            if (stuff_slot) begin
                // Stuff bit: never reaches the field logic, so a stuff error
                // always wins over anything else decoded on this sample.
                if (rx_bit == last_bit_reg) begin
                    stuff_error_next = 1'b1;
                    enter_wait       = 1'b1;
                end else begin
                    run_cnt_next  = 3'd1;
                    last_bit_next = rx_bit;
                end
            end else begin
                if (destuff_active) begin
                    run_cnt_next  = (rx_bit == last_bit_reg) ? run_cnt_reg + 3'd1 : 3'd1;
                    last_bit_next = rx_bit;
                end
                if (state_reg inside {ST_ID, ST_RTR, ST_IDE, ST_R0, ST_DLC, ST_DATA})
                    crc_next = crc_step(crc_reg, rx_bit);

                case (state_reg)
                    ST_IDLE: begin
                        if (!rx_bit) begin
                            // SOF: a zero into a zero CRC leaves it zero
                            state_next    = ST_ID;
                            bit_cnt_next  = '0;
                            run_cnt_next  = 3'd1;
                            last_bit_next = 1'b0;
                            crc_next      = '0;
                        end
                    end
                    ST_ID: begin
                        id_next = {id_reg[9:0], rx_bit};
                        if (bit_cnt_reg == 7'd10) begin
                            state_next   = ST_RTR;
                            bit_cnt_next = '0;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 7'd1;
                        end
                    end
                    ST_RTR: begin
                        rtr_next   = rx_bit;
                        state_next = ST_IDE;
                    end
                    ST_IDE: begin
                        if (rx_bit) begin
                            form_error_next = 1'b1;
                            enter_wait      = 1'b1;
                        end else begin
                            state_next = ST_R0;
                        end
                    end
                    ST_R0: begin
                        state_next   = ST_DLC;
                        bit_cnt_next = '0;
                    end
                    ST_DLC: begin
                        dlc_next = dlc_shift;
                        if (bit_cnt_reg == 7'd3) begin
                            bit_cnt_next = '0;
                            state_next   = (frame_bytes(rtr_reg, dlc_shift) == 4'd0) ? ST_CRC : ST_DATA;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 7'd1;
                        end
                    end
                    ST_DATA: begin
                        // bit_cnt[5:3] selects the byte, bits arrive MSB first
                        data_next[bit_cnt_reg[5:3]][3'd7 - bit_cnt_reg[2:0]] = rx_bit;
                        if (bit_cnt_reg == {n_bytes, 3'b000} - 7'd1) begin
                            state_next   = ST_CRC;
                            bit_cnt_next = '0;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 7'd1;
                        end
                    end
                    ST_CRC: begin
                        crc_rx_next = {crc_rx_reg[13:0], rx_bit};
                        if (bit_cnt_reg == 7'd14) begin
                            state_next   = ST_CRC_DELIM;
                            bit_cnt_next = '0;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 7'd1;
                        end
                    end
                    ST_CRC_DELIM: begin
                        if (!rx_bit) begin
                            form_error_next = 1'b1;
                            enter_wait      = 1'b1;
                        end else if (crc_rx_reg != crc_reg) begin
                            // No acknowledge; the frame is abandoned here
                            crc_error_next = 1'b1;
                            enter_wait     = 1'b1;
                        end else begin
                            state_next = ST_ACK_SLOT;
                        end
                    end
                    ST_ACK_SLOT: begin
                        state_next = ST_ACK_DELIM;
                    end
                    ST_ACK_DELIM: begin
                        if (!rx_bit) begin
                            form_error_next = 1'b1;
                            enter_wait      = 1'b1;
                        end else begin
                            state_next   = ST_EOF;
                            bit_cnt_next = '0;
                        end
                    end
                    ST_EOF: begin
                        if (!rx_bit) begin
                            form_error_next = 1'b1;
                            enter_wait      = 1'b1;
                        end else if (bit_cnt_reg == 7'd6) begin
                            state_next      = ST_IDLE;
                            bit_cnt_next    = '0;
                            rx_done_next    = 1'b1;
                            rx_data_next[0] = id_reg[10:3];
                            rx_data_next[1] = {id_reg[2:0], rtr_reg, dlc_reg};
                            // Bytes beyond the data length may hold stale
                            // contents from an earlier frame; mask them.
                            for (int i = 0; i < 8; i++)
                                rx_data_next[i + 2] = (4'(i) < n_bytes) ? data_reg[i] : 8'h00;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 7'd1;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (rx_bit) begin
                            if (wait_cnt_reg == 4'd10) begin
                                state_next    = ST_IDLE;
                                wait_cnt_next = '0;
                            end else begin
                                wait_cnt_next = wait_cnt_reg + 4'd1;
                            end
                        end else begin
                            wait_cnt_next = '0;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                    end
                endcase
            end

            if (enter_wait) begin
                state_next    = ST_WAIT_IDLE;
                wait_cnt_next = '0;
                bit_cnt_next  = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Only good frames ever reach ACK_SLOT, so the state alone decides the ACK.
    assign ack_bit     = (state_reg != ST_ACK_SLOT);
    assign rx_busy     = (state_reg != ST_IDLE);
    assign rx_done     = rx_done_reg;
    assign crc_error   = crc_error_reg;
    assign stuff_error = stuff_error_reg;
    assign form_error  = form_error_reg;

    assign rx_data_0 = rx_data_reg[0];
    assign rx_data_1 = rx_data_reg[1];
    assign rx_data_2 = rx_data_reg[2];
    assign rx_data_3 = rx_data_reg[3];
    assign rx_data_4 = rx_data_reg[4];
    assign rx_data_5 = rx_data_reg[5];
    assign rx_data_6 = rx_data_reg[6];
    assign rx_data_7 = rx_data_reg[7];
    assign rx_data_8 = rx_data_reg[8];
    assign rx_data_9 = rx_data_reg[9];

endmodule

// File: tb/tb_can_receiver.sv
// -----------------------------------------------------------------------------
// tb_can_receiver
//
// Directed frames are serialised onto rx_bit, one sample_point every 4 clocks.
// Each frame pushes its expected outcome (event kind, frame bytes, number of
// cycles ack_bit is low) into a queue; a monitor pops and compares whenever
// the receiver raises rx_done or an error flag.
// -----------------------------------------------------------------------------
module tb_can_receiver;

    localparam int K_DONE  = 0;
    localparam int K_CRC   = 1;
    localparam int K_STUFF = 2;
    localparam int K_FORM  = 3;
    localparam int BIT_CLKS = 4;

    typedef struct {
        int          kind;
        logic [79:0] data;
        int          ack_cycles;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_point;
    logic       rx_bit;
    logic [7:0] rx_data_0, rx_data_1, rx_data_2, rx_data_3, rx_data_4;
    logic [7:0] rx_data_5, rx_data_6, rx_data_7, rx_data_8, rx_data_9;
    logic       rx_done, ack_bit, crc_error, stuff_error, form_error, rx_busy;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    bit          line_q[$];
    logic [79:0] last_good = '0;
    int          ack_low = 0;

    can_receiver dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_point (sample_point),
        .rx_bit       (rx_bit),
        .rx_data_0    (rx_data_0),
        .rx_data_1    (rx_data_1),
        .rx_data_2    (rx_data_2),
        .rx_data_3    (rx_data_3),
        .rx_data_4    (rx_data_4),
        .rx_data_5    (rx_data_5),
        .rx_data_6    (rx_data_6),
        .rx_data_7    (rx_data_7),
        .rx_data_8    (rx_data_8),
        .rx_data_9    (rx_data_9),
        .rx_done      (rx_done),
        .ack_bit      (ack_bit),
        .crc_error    (crc_error),
        .stuff_error  (stuff_error),
        .form_error   (form_error),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    wire [79:0] rx_all = {rx_data_0, rx_data_1, rx_data_2, rx_data_3, rx_data_4,
                          rx_data_5, rx_data_6, rx_data_7, rx_data_8, rx_data_9};

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] crc_step(input logic [14:0] c, input bit b);
        logic fb;
        fb = b ^ c[14];
        c  = {c[13:0], 1'b0};
        if (fb) c = c ^ 15'h4599;
        return c;
    endfunction

    task automatic expect_event(input int kind, input logic [79:0] data, input int ack_cycles);
        exp_t e;
        e.kind       = kind;
        e.data       = data;
        e.ack_cycles = ack_cycles;
        exp_q.push_back(e);
    endtask

    // Serialise a standard frame into line_q: stuffing from SOF through the
    // last CRC bit, then delimiters, EOF and 11 idle recessive bits.
    // flip_bit >= 0 inverts that data bit after the CRC was computed.
    task automatic build_frame(input logic [10:0] id, input bit rtr, input bit ide,
                               input logic [3:0] dlc, input logic [63:0] data,
                               input int flip_bit, input bit bad_delim);
        bit          raw[$];
        logic [14:0] crc;
        int          n;
        int          run;
        bit          last;
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(ide);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 63; i >= 64 - 8 * n; i--) raw.push_back(data[i]);
        crc = '0;
        foreach (raw[i]) crc = crc_step(crc, raw[i]);
        if (flip_bit >= 0) raw[19 + flip_bit] = ~raw[19 + flip_bit];
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        line_q.delete();
        run  = 0;
        last = 1'b1;
        for (int i = 0; i < raw.size(); i++) begin
            line_q.push_back(raw[i]);
            if (raw[i] == last) run++;
            else begin
                run  = 1;
                last = raw[i];
            end
            if (run == 5 && i != raw.size() - 1) begin
                line_q.push_back(~last);
                last = ~last;
                run  = 1;
            end
        end
        line_q.push_back(~bad_delim);
        line_q.push_back(1'b1);
        line_q.push_back(1'b1);
        for (int i = 0; i < 7 + 11; i++) line_q.push_back(1'b1);
    endtask

    task automatic send_bit(input bit b);
        rx_bit       = b;
        sample_point = 1'b0;
        repeat (BIT_CLKS - 1) @(negedge clk);
        sample_point = 1'b1;
        @(negedge clk);
        sample_point = 1'b0;
    endtask

    task automatic send_line(input int count);
        for (int i = 0; i < count && i < line_q.size(); i++) send_bit(line_q[i]);
    endtask

    // Monitor: compares each DUT output event against the queue head
    initial begin
        int   act_kind;
        int   nflags;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (ack_bit === 1'b0) ack_low++;
                nflags = int'(rx_done) + int'(crc_error) + int'(stuff_error) + int'(form_error);
                if (nflags != 0) begin
                    act_kind = (nflags > 1) ? 9 :
                               rx_done     ? K_DONE :
                               crc_error   ? K_CRC :
                               stuff_error ? K_STUFF : K_FORM;
                    $display("event kind=%0d data=%h ack_low=%0d", act_kind, rx_all, ack_low);
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", 80'(act_kind), 80'(99));
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind", 80'(act_kind), 80'(e.kind));
                        check("rx_data", rx_all, e.data);
                        check("ack_low_cycles", 80'(ack_low), 80'(e.ack_cycles));
                    end
                    ack_low = 0;
                end
            end
        end
    end

    localparam logic [79:0] F1_DATA = {8'hAA, 8'h88, 64'h1122334455667788};

    initial begin
        rst_n        = 1'b0;
        sample_point = 1'b0;
        rx_bit       = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", rx_all, '0);
        check("reset_flags", {76'd0, rx_done, crc_error, stuff_error, form_error}, '0);
        check("reset_ack_busy", {78'd0, ack_bit, rx_busy}, 80'b10);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Valid data frame, DLC=8
        build_frame(11'h554, 1'b0, 1'b0, 4'd8, 64'h1122334455667788, -1, 1'b0);
        expect_event(K_DONE, F1_DATA, BIT_CLKS);
        last_good = F1_DATA;
        send_line(line_q.size());
        check("idle_after_frame1", 80'(rx_busy), 80'(0));

        // Stuff violation: SOF then six recessive ID bits
        expect_event(K_STUFF, last_good, 0);
        send_bit(1'b0);
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        check("busy_after_10_recessive", 80'(rx_busy), 80'(1));
        send_bit(1'b1);
        check("idle_after_11_recessive", 80'(rx_busy), 80'(0));

        // CRC violation: one data bit flipped
        build_frame(11'h0F0, 1'b0, 1'b0, 4'd2, 64'hA55A000000000000, 3, 1'b0);
        expect_event(K_CRC, last_good, 0);
        send_line(line_q.size());

        // Form error: CRC delimiter dominant
        build_frame(11'h7FF, 1'b0, 1'b0, 4'd1, 64'h3C00000000000000, -1, 1'b1);
        expect_event(K_FORM, last_good, 0);
        send_line(line_q.size());

        // Form error: IDE=1
        build_frame(11'h2AB, 1'b0, 1'b1, 4'd1, 64'h5500000000000000, -1, 1'b0);
        expect_event(K_FORM, last_good, 0);
        send_line(line_q.size());

        // Remote frame, DLC=4: no data consumed, bytes read 0x00
        build_frame(11'h123, 1'b1, 1'b0, 4'd4, 64'hFFFFFFFFFFFFFFFF, -1, 1'b0);
        last_good = {8'h24, 8'h74, 64'h0};
        expect_event(K_DONE, last_good, BIT_CLKS);
        send_line(line_q.size());

        // DLC=3: bytes 4..8 must read 0x00 although old data lingers inside
        build_frame(11'h1A5, 1'b0, 1'b0, 4'd3, 64'hDEADBE0000000000, -1, 1'b0);
        last_good = {8'h34, 8'hA3, 64'hDEADBE0000000000};
        expect_event(K_DONE, last_good, BIT_CLKS);
        send_line(line_q.size());

        // DLC=12 carries 8 bytes
        build_frame(11'h001, 1'b0, 1'b0, 4'd12, 64'h0102030405060708, -1, 1'b0);
        last_good = {8'h00, 8'h2C, 64'h0102030405060708};
        expect_event(K_DONE, last_good, BIT_CLKS);
        send_line(line_q.size());

        // Reset in the middle of the DATA field
        build_frame(11'h554, 1'b0, 1'b0, 4'd8, 64'h1122334455667788, -1, 1'b0);
        send_line(40);
        check("busy_mid_frame", 80'(rx_busy), 80'(1));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_data", rx_all, '0);
        check("midreset_flags", {76'd0, rx_done, crc_error, stuff_error, form_error}, '0);
        check("midreset_ack_busy", {78'd0, ack_bit, rx_busy}, 80'b10);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        last_good = '0;
        for (int i = 0; i < 3; i++) send_bit(1'b1);

        // Following valid frame received correctly
        expect_event(K_DONE, F1_DATA, BIT_CLKS);
        send_line(line_q.size());

        repeat (10) @(negedge clk);
        check("pending_events", 80'(exp_q.size()), 80'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
